// File: rtl/xt_fetch_ctrl.sv
// xt_fetch_ctrl: walks a tile address range in the x_t buffer ROM and qualifies its output stream.
module xt_fetch_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_tiles,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W:0]   out_idx
);
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   idx, count;
  logic              fire;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign rom_en    = state == PRIME || state == STREAM;
  assign out_valid = state == STREAM && !abort;
  assign out_last  = state == STREAM && idx == count - 1'b1;
  assign fire      = out_valid && out_ready;
  // Look ahead one address on an accepted tile so the next word lands on dout_vec without a bubble.
  assign rom_addr  = (fire && !out_last) ? cur_addr + 1'b1 : cur_addr;
  assign out_idx   = idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      idx      <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur_addr <= base_addr;
          idx      <= '0;
          count    <= num_tiles;
          state    <= num_tiles == '0 ? DONE : PRIME;
        end
        PRIME: state <= abort ? IDLE : STREAM;
        STREAM: begin
          if (abort) state <= IDLE;
          else if (fire && out_last) state <= DONE;
          else if (fire) begin
            cur_addr <= cur_addr + 1'b1;
            idx      <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xt_fetch_ctrl.sv
// tb_xt_fetch_ctrl: directed checks of xt_fetch_ctrl against a one-cycle-latency ROM model.
module tb_xt_fetch_ctrl;
  logic        clk = 0;
  logic        rst, start, abort, out_ready;
  logic [5:0]  base_addr;
  logic [6:0]  num_tiles;
  logic        busy, done, rom_en, out_valid, out_last;
  logic [5:0]  rom_addr;
  logic [6:0]  out_idx;
  logic [15:0] dout;
  int          n_tests = 0, n_fail = 0;

  xt_fetch_ctrl #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .abort(abort), .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  // buffer model: mem[i] = i, zero when not enabled
  always_ff @(posedge clk) dout <= rom_en ? {10'd0, rom_addr} : 16'd0;

  task automatic test_reset;
    rst = 1; start = 0; abort = 0; out_ready = 0; base_addr = 0; num_tiles = 0;
    #3;
    n_tests++;
    if ({busy, done, rom_en, out_valid, out_last} !== 5'b0 || rom_addr !== 6'd0 || out_idx !== 7'd0) begin
      n_fail++;
      $display("FAIL reset: flags=%b rom_addr=%0d out_idx=%0d required all zero",
               {busy, done, rom_en, out_valid, out_last}, rom_addr, out_idx);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_basic;
    logic [5:0] ea;
    @(posedge clk); #1 start = 1; base_addr = 3; num_tiles = 4; out_ready = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    n_tests++;
    if (rom_en !== 1 || rom_addr !== 6'd3 || out_valid !== 0 || busy !== 1) begin
      n_fail++;
      $display("FAIL basic_prime: en=%b addr=%0d valid=%b busy=%b required 1,3,0,1", rom_en, rom_addr, out_valid, busy);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      ea = (k == 3) ? 6'd6 : 6'(4 + k);
      n_tests++;
      if (out_valid !== 1 || dout !== 16'(3 + k) || out_idx !== 7'(k) || out_last !== (k == 3) || rom_addr !== ea) begin
        n_fail++;
        $display("FAIL basic_tile%0d: valid=%b dout=%0d idx=%0d last=%b addr=%0d required 1,%0d,%0d,%b,%0d",
                 k, out_valid, dout, out_idx, out_last, rom_addr, 3 + k, k, k == 3, ea);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (done !== 1 || rom_en !== 0 || out_valid !== 0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b en=%b valid=%b required 1,0,0", done, rom_en, out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (busy !== 0 || done !== 0) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b done=%b required 0,0", busy, done);
    end
  endtask

  task automatic test_backpressure;
    logic        rdy [6] = '{1, 0, 0, 1, 0, 1};
    logic [15:0] et  [6] = '{10, 11, 11, 11, 12, 12};
    logic [5:0]  ea  [6] = '{11, 11, 11, 12, 12, 12};
    @(posedge clk); #1 start = 1; base_addr = 10; num_tiles = 3; out_ready = 0;
    @(posedge clk); #1 start = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 out_ready = rdy[c];
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1 || dout !== et[c] || rom_addr !== ea[c]) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: valid=%b dout=%0d addr=%0d required 1,%0d,%0d", c, out_valid, dout, rom_addr, et[c], ea[c]);
      end
    end
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    n_tests++;
    if (done !== 1 || out_valid !== 0) begin
      n_fail++;
      $display("FAIL bp_done: done=%b valid=%b required 1,0", done, out_valid);
    end
  endtask

  task automatic test_wrap(input logic [5:0] b, input int n);
    int         dones = 0, tiles = 0, bad = 0;
    logic [5:0] a;
    @(posedge clk); #1 start = 1; base_addr = b; num_tiles = 7'(n); out_ready = 1;
    for (int c = 1; c <= n + 3; c++) begin
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      if (done) dones++;
      if (out_valid) begin
        a = b + 6'(tiles);
        if (dout !== {10'd0, a} || out_idx !== 7'(tiles) || out_last !== (tiles == n - 1) || c != tiles + 2) bad++;
        tiles++;
      end
    end
    n_tests++;
    if (bad != 0 || tiles != n || dones != 1 || busy !== 0) begin
      n_fail++;
      $display("FAIL wrap_b%0d_n%0d: bad=%0d tiles=%0d dones=%0d busy=%b required 0,%0d,1,0", b, n, bad, tiles, dones, busy, n);
    end
  endtask

  task automatic test_zero_and_busy_start;
    int tiles = 0, dones = 0;
    @(posedge clk); #1 start = 1; base_addr = 9; num_tiles = 0; out_ready = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    n_tests++;
    if (done !== 1 || out_valid !== 0 || rom_en !== 0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b valid=%b en=%b required 1,0,0", done, out_valid, rom_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (busy !== 0 || rom_en !== 0) begin
      n_fail++;
      $display("FAIL zero_idle: busy=%b en=%b required 0,0", busy, rom_en);
    end
    @(posedge clk); #1 start = 1; base_addr = 40; num_tiles = 3;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1 start = (c == 3); base_addr = 0; num_tiles = 5;
      @(negedge clk);
      if (out_valid) begin
        if (dout === 16'(40 + tiles)) tiles++;
      end
      if (done) dones++;
    end
    start = 0;
    n_tests++;
    if (tiles != 3 || dones != 1 || busy !== 0) begin
      n_fail++;
      $display("FAIL busy_start: tiles=%0d dones=%0d busy=%b required 3,1,0", tiles, dones, busy);
    end
  endtask

  task automatic test_abort;
    int xfers = 0;
    @(posedge clk); #1 start = 1; base_addr = 0; num_tiles = 8; out_ready = 1;
    @(posedge clk); #1 start = 0;
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1 abort = (c == 4);
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
    end
    n_tests++;
    if (xfers != 2 || out_valid !== 0) begin
      n_fail++;
      $display("FAIL abort_cycle: xfers=%0d valid=%b required 2,0", xfers, out_valid);
    end
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    n_tests++;
    if (busy !== 0 || done !== 0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b required 0,0", busy, done);
    end
    @(posedge clk); #1 start = 1; base_addr = 7; num_tiles = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1 || dout !== 16'd7 || out_last !== 1) begin
      n_fail++;
      $display("FAIL abort_restart: valid=%b dout=%0d last=%b required 1,7,1", out_valid, dout, out_last);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (done !== 1) begin
      n_fail++;
      $display("FAIL abort_restart_done: done=%b required 1", done);
    end
  endtask

  task automatic test_reset_mid_run;
    @(posedge clk); #1 start = 1; base_addr = 30; num_tiles = 10; out_ready = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    @(negedge clk); #2 rst = 1;
    #1;
    n_tests++;
    if ({busy, done, rom_en, out_valid, out_last} !== 5'b0 || rom_addr !== 6'd0 || out_idx !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_mid: flags=%b rom_addr=%0d out_idx=%0d required all zero",
               {busy, done, rom_en, out_valid, out_last}, rom_addr, out_idx);
    end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 start = 1; base_addr = 20; num_tiles = 2;
    @(posedge clk); #1 start = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1 || dout !== 16'(20 + k) || out_last !== (k == 1)) begin
        n_fail++;
        $display("FAIL reset_rerun%0d: valid=%b dout=%0d last=%b required 1,%0d,%b", k, out_valid, dout, out_last, 20 + k, k == 1);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (done !== 1) begin
      n_fail++;
      $display("FAIL reset_rerun_done: done=%b required 1", done);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap(6'd62, 4);
    test_wrap(6'd5, 64);
    test_zero_and_busy_start;
    test_abort;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/xt_fetch_ctrl.md
# xt_fetch_ctrl

Sequencer for the x_t input buffer ROM. On a start command it walks a contiguous range of tile addresses, drives the buffer's `en`/`addr`, and absorbs the buffer's one-cycle read latency. It presents each 4×16-bit tile to the downstream consumer with a valid/ready handshake at up to one tile per cycle. It sits between the top-level controller and the buffer; tile data flows directly from the buffer's `dout_vec`, and this block supplies only the qualifiers.

## Interface
- `ADDR_W`, 6, buffer address width; depth = 2^ADDR_W tiles
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a fetch run; sampled only in IDLE
- `base_addr`  in  ADDR_W  first tile address, captured on accepted start
- `num_tiles`  in  ADDR_W+1  tiles to fetch (0..2^ADDR_W), captured on accepted start
- `abort`  in  1  cancel current run
- `busy`  out  1  high in PRIME/STREAM/DONE
- `done`  out  1  one-cycle pulse after final tile accepted
- `rom_en`  out  1  to buffer `en`
- `rom_addr`  out  ADDR_W  to buffer `addr`
- `out_valid`  out  1  buffer `dout_vec` holds current tile
- `out_ready`  in  1  consumer accepts tile
- `out_last`  out  1  current tile is final of run (qualified by out_valid)
- `out_idx`  out  ADDR_W+1  zero-based tile index within run

## Operation
- States: IDLE, PRIME, STREAM, DONE.
- IDLE:
  - `start`=1 and `num_tiles`≠0: capture base/count; cur_addr←base_addr, idx←0; go PRIME.
  - `start`=1 and `num_tiles`=0: go DONE directly (no ROM access).
- PRIME (1 cycle): rom_en=1, rom_addr=cur_addr; go STREAM.
- STREAM: rom_en=1, out_valid=1; fire = out_valid & out_ready.
  - rom_addr = (fire & !out_last) ? cur_addr+1 : cur_addr (combinational from out_ready).
  - On fire with !out_last: cur_addr←cur_addr+1, idx←idx+1.
  - On fire with out_last: go DONE.
  - Stall (out_ready=0): address held, buffer re-reads same word, so dout_vec stays stable; out_valid held.
- DONE (1 cycle): done=1, rom_en=0; go IDLE.
- out_last = (idx == count−1); out_idx = idx.
- Address arithmetic: modulo 2^ADDR_W; a run crossing the top wraps to 0 (base 62, 4 tiles, ADDR_W=6 → 62,63,0,1). num_tiles=2^ADDR_W reads every address once.
- `start` outside IDLE is ignored (no queueing); base/count changes after capture have no effect.
- `abort` (any busy state): out_valid forced 0 combinationally in that cycle (no transfer counts); next edge → IDLE; no done pulse. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start wins (abort ignored in IDLE).

## Timing
- Reset (async assert): state IDLE; busy, done, rom_en, out_valid, out_last = 0; rom_addr, out_idx = 0; internal regs 0. Reset mid-run discards the run immediately; no done.
- Start sampled at edge 0 → PRIME in cycle 1 (rom_en=1, rom_addr=base) → cycle 2 out_valid=1 with tile[base] on dout_vec. Start-to-first-valid latency: 2 cycles.
- Throughput: 1 tile/cycle with out_ready held high; run of N tiles, ready always high: valid cycles 2..N+1, done in cycle N+2, IDLE (busy=0) in cycle N+3, next start accepted that cycle.
- num_tiles=0: start at edge 0 → done=1 in cycle 1 → IDLE cycle 2.
- rom_en is 0 in IDLE and DONE, so buffer dout_vec reads zero outside a run.

## Test plan
- Basic: ADDR_W=6, mem[i]=i-pattern, start base=3 num=4, ready=1 → out_valid cycles 2–5, tiles 3,4,5,6, out_idx 0–3, out_last only on tile 6, done in cycle 6, busy low in cycle 7.
- Backpressure: base=10 num=3, ready toggling 1,0,0,1,0,1 → each tile held stable while ready=0, tiles 10,11,12 each delivered exactly once in order, rom_addr never advances on stall.
- Wrap: base=62 num=4 → tiles 62,63,0,1; num=64 base=5 → 64 tiles, 5..63 then 0..4, single done.
- Zero length and start-while-busy: num=0 → done in cycle 1, no out_valid, rom_en stays 0; start pulsed mid-run → ignored, run count unchanged.
- Abort: base=0 num=8, abort during 3rd valid cycle with ready=1 → only 2 tiles transferred, out_valid 0 in abort cycle, IDLE next cycle, no done; new start then works normally.
- Reset mid-run: assert rst asynchronously during STREAM → all outputs 0 immediately; after release, start base=20 num=2 → tiles 20,21, correct done.
